// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash values and the round helper functions.
// Pure declarations: no timing, no flow control.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef logic [0:7][31:0] state8_t;   // index 0 = a / H0

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam state8_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam state8_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t Sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t Sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t Ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t Maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round on the a..h working set.
// Zero latency, no flow control; chained UNROLL times by the sequencer.
module sha256_round
    import sha256_pkg::*;
(
    input  state8_t i_st,
    input  word_t   i_k,
    input  word_t   i_w,
    output state8_t o_st
);

    word_t w_t1;
    word_t w_t2;

    always_comb begin
        w_t1 = i_st[7] + Sigma1(i_st[4]) + Ch(i_st[4], i_st[5], i_st[6]) + i_k + i_w;
        w_t2 = Sigma0(i_st[0]) + Maj(i_st[0], i_st[1], i_st[2]);
        o_st = {w_t1 + w_t2, i_st[0], i_st[1], i_st[2], i_st[3] + w_t1, i_st[4], i_st[5], i_st[6]};
    end

endmodule

// File: rtl/sha256_seq.sv
// Iterative SHA-256 block sequencer, UNROLL rounds/clock; digest valid 64/UNROLL+1 edges after accept, held until out_ready.
// SHA256_SEQ_SHA224_EN adds in_sha224 to select the SHA-224 IV and truncate the digest.
module sha256_seq
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
`ifdef SHA256_SEQ_SHA224_EN
    input  logic         in_sha224,
`endif
    input  logic [0:511] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:255] digest
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("sha256_seq: UNROLL must be 1, 2 or 4");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    state8_t    r_h;
    state8_t    r_v;
    state8_t    r_digest;
    word_t      r_w [16];
    logic [5:0] r_cnt;
    logic       w_accept;
    state8_t    w_iv;
    state8_t    w_h_new;
    state8_t    w_dig_new;
    word_t      w_ext [16+UNROLL];
    word_t      w_k [UNROLL];
    state8_t    w_chain [UNROLL+1];

`ifdef SHA256_SEQ_SHA224_EN
    logic r_sha224;
    assign w_iv = in_sha224 ? IV224 : IV256;
`else
    assign w_iv = IV256;
`endif

    // Extended schedule window: entries 16.. are the words needed by this cycle's rounds.
    for (genvar i = 0; i < 16; i++) begin : g_win
        assign w_ext[i] = r_w[i];
    end
    for (genvar k = 0; k < UNROLL; k++) begin : g_sched
        assign w_ext[16+k] = sigma1(w_ext[14+k]) + w_ext[9+k] + sigma0(w_ext[1+k]) + w_ext[k];
    end

    assign w_chain[0] = r_v;
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        assign w_k[j] = K[r_cnt + 6'(j)];
        sha256_round u_round (
            .i_st (w_chain[j]),
            .i_k  (w_k[j]),
            .i_w  (w_ext[j]),
            .o_st (w_chain[j+1])
        );
    end

    for (genvar i = 0; i < 8; i++) begin : g_hadd
        assign w_h_new[i] = r_h[i] + r_v[i];
    end

    always_comb begin
        w_dig_new = w_h_new;
`ifdef SHA256_SEQ_SHA224_EN
        if (r_sha224) begin
            w_dig_new[7] = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == 6'(64 - UNROLL)) begin
                    w_state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: w_state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h      <= IV256;
            r_v      <= '0;
            r_digest <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
`ifdef SHA256_SEQ_SHA224_EN
            r_sha224 <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= in_block[i*32 +: 32];
                        end
                        if (in_first) begin
                            r_h <= w_iv;
                            r_v <= w_iv;
`ifdef SHA256_SEQ_SHA224_EN
                            r_sha224 <= in_sha224;
`endif
                        end else begin
                            r_v <= r_h;
                        end
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_v <= w_chain[UNROLL];
                    for (int i = 0; i < 16; i++) begin
                        r_w[i] <= w_ext[i+UNROLL];
                    end
                    r_cnt <= r_cnt + 6'(UNROLL);
                end
                ST_FINAL: begin
                    r_h      <= w_h_new;
                    r_digest <= w_dig_new;
                end
                default: ;
            endcase
        end
    end

    assign digest = r_digest;

endmodule
